// File: rtl/hpdcache_sram_1rw_ctrl_if.sv
// ----------------------------------------------------------------------------
// hpdcache_sram_1rw_ctrl_if
//   Groups every signal that passes between the single-port SRAM bank
//   controller, its two requesters (read and write) and the SRAM macro.
//
//   init_req / init_busy      : on-demand zeroing request and busy status
//   rd_valid/ready/addr       : read request handshake
//   rd_rvalid/rd_rdata        : read response (no backpressure)
//   wr_valid/ready/addr/data/be: write request handshake
//   sram_*                    : SRAM macro drive and registered read data
//
//   slave  : controller view
//   master : requester + SRAM view
// ----------------------------------------------------------------------------
interface hpdcache_sram_1rw_ctrl_if #(
  parameter int unsigned ADDR_SIZE = 6,
  parameter int unsigned DATA_SIZE = 64
);
  localparam int unsigned BE_SIZE = DATA_SIZE / 8;

  logic                 init_req;
  logic                 init_busy;

  logic                 rd_valid;
  logic                 rd_ready;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 rd_rvalid;
  logic [DATA_SIZE-1:0] rd_rdata;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [DATA_SIZE-1:0] wr_data;
  logic [BE_SIZE-1:0]   wr_be;

  logic                 sram_cs;
  logic                 sram_we;
  logic [ADDR_SIZE-1:0] sram_addr;
  logic [DATA_SIZE-1:0] sram_wdata;
  logic [BE_SIZE-1:0]   sram_wbyteenable;
  logic [DATA_SIZE-1:0] sram_rdata;

  modport slave (
    input  init_req,
    output init_busy,
    input  rd_valid, rd_addr,
    output rd_ready, rd_rvalid, rd_rdata,
    input  wr_valid, wr_addr, wr_data, wr_be,
    output wr_ready,
    output sram_cs, sram_we, sram_addr, sram_wdata, sram_wbyteenable,
    input  sram_rdata
  );

  modport master (
    output init_req,
    input  init_busy,
    output rd_valid, rd_addr,
    input  rd_ready, rd_rvalid, rd_rdata,
    output wr_valid, wr_addr, wr_data, wr_be,
    input  wr_ready,
    input  sram_cs, sram_we, sram_addr, sram_wdata, sram_wbyteenable,
    output sram_rdata
  );
endinterface

// File: rtl/hpdcache_sram_1rw_ctrl.sv
// ----------------------------------------------------------------------------
// hpdcache_sram_1rw_ctrl
//   Owns one single-port byte-enable SRAM bank. Arbitrates round-robin
//   between a read and a write requester and zero-fills the whole array
//   after reset (optional) and whenever init_req is pulsed in RUN.
//
//   clk_i   : clock
//   rst_i   : asynchronous reset, active-high
//   bus_io  : request/response/SRAM bundle (slave modport)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   INIT  | writing zeros to addresses 0..DEPTH-1, one per cycle, no grants
//   RUN   | arbitrating read/write requests onto the SRAM
//
//   DATA_SIZE must be a multiple of 8; the interface instance must use the
//   same ADDR_SIZE/DATA_SIZE as this module.
// ----------------------------------------------------------------------------
module hpdcache_sram_1rw_ctrl #(
  parameter int unsigned ADDR_SIZE     = 6,
  parameter int unsigned DATA_SIZE     = 64,
  parameter int unsigned DEPTH         = 2 ** ADDR_SIZE,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  hpdcache_sram_1rw_ctrl_if.slave  bus_io
);

  localparam int unsigned          BE_SIZE   = DATA_SIZE / 8;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam state_e RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

  state_e               state_q,    state_d;
  logic [ADDR_SIZE-1:0] init_cnt_q, init_cnt_d;
  logic                 rr_prio_q,  rr_prio_d;
  logic                 rd_rvalid_q, rd_rvalid_d;

  logic                 rd_gnt;
  logic                 wr_gnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RESET_STATE;
      init_cnt_q  <= '0;
      rr_prio_q   <= 1'b0;
      rd_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_prio_q   <= rr_prio_d;
      rd_rvalid_q <= rd_rvalid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rr_prio_d  = rr_prio_q;
    rd_gnt     = 1'b0;
    wr_gnt     = 1'b0;

    bus_io.init_busy        = 1'b0;
    bus_io.sram_cs          = 1'b0;
    bus_io.sram_we          = 1'b0;
    bus_io.sram_addr        = '0;
    bus_io.sram_wdata       = '0;
    bus_io.sram_wbyteenable = '0;

    unique case (state_q)
      ST_INIT: begin
        // Fixed-length zero fill; requester activity cannot stretch it.
        bus_io.init_busy        = 1'b1;
        bus_io.sram_cs          = 1'b1;
        bus_io.sram_we          = 1'b1;
        bus_io.sram_addr        = init_cnt_q;
        bus_io.sram_wbyteenable = {BE_SIZE{1'b1}};
        if (init_cnt_q == LAST_ADDR) begin
          init_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + ADDR_SIZE'(1);
        end
      end

      ST_RUN: begin
        if (bus_io.init_req) begin
          state_d = ST_INIT;
        end else if (bus_io.rd_valid && (!bus_io.wr_valid || !rr_prio_q)) begin
          rd_gnt = 1'b1;
        end else if (bus_io.wr_valid) begin
          wr_gnt = 1'b1;
        end

        // The priority flips to the loser after every grant, so two
        // persistent contenders strictly alternate.
        if (rd_gnt) begin
          rr_prio_d        = 1'b1;
          bus_io.sram_cs   = 1'b1;
          bus_io.sram_addr = bus_io.rd_addr;
        end else if (wr_gnt) begin
          rr_prio_d               = 1'b0;
          bus_io.sram_cs          = 1'b1;
          bus_io.sram_we          = 1'b1;
          bus_io.sram_addr        = bus_io.wr_addr;
          bus_io.sram_wdata       = bus_io.wr_data;
          bus_io.sram_wbyteenable = bus_io.wr_be;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // The macro registers its read data, so the response flag just tracks the
  // grant by one cycle and the data is a straight pass-through.
  assign rd_rvalid_d      = rd_gnt;
  assign bus_io.rd_ready  = rd_gnt;
  assign bus_io.wr_ready  = wr_gnt;
  assign bus_io.rd_rvalid = rd_rvalid_q;
  assign bus_io.rd_rdata  = bus_io.sram_rdata;

endmodule

// File: tb/tb_hpdcache_sram_1rw_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hpdcache_sram_1rw_ctrl
//   Directed bench with a behavioural byte-enable SRAM (registered read data).
//   Inputs change 1 time unit after posedge, outputs are sampled at negedge.
// ----------------------------------------------------------------------------
module tb_hpdcache_sram_1rw_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  hpdcache_sram_1rw_ctrl_if #(.ADDR_SIZE(6), .DATA_SIZE(64)) bus ();

  hpdcache_sram_1rw_ctrl #(
    .ADDR_SIZE(6), .DATA_SIZE(64), .DEPTH(64), .INIT_ON_RESET(1'b1)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  logic [63:0] mem [64];

  always @(posedge clk) begin
    if (bus.sram_cs) begin
      if (bus.sram_we) begin
        for (int b = 0; b < 8; b++)
          if (bus.sram_wbyteenable[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      end else begin
        bus.sram_rdata <= mem[bus.sram_addr];
      end
    end
  end

  typedef struct {
    logic        rdv, wrv, ireq;
    logic [5:0]  ra, wa;
    logic [63:0] wd;
    logic [7:0]  be;
    logic        e_rr, e_wr, e_cs, e_we;
    logic [5:0]  e_addr;
    logic        e_rv, chk_d;
    logic [63:0] e_rd;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(logic rdv, logic wrv, logic ireq, logic [5:0] ra, logic [5:0] wa,
                              logic [63:0] wd, logic [7:0] be, logic e_rr, logic e_wr,
                              logic e_cs, logic e_we, logic [5:0] e_addr, logic e_rv,
                              logic chk_d, logic [63:0] e_rd);
    vec_t v;
    v.rdv = rdv; v.wrv = wrv; v.ireq = ireq; v.ra = ra; v.wa = wa; v.wd = wd; v.be = be;
    v.e_rr = e_rr; v.e_wr = e_wr; v.e_cs = e_cs; v.e_we = e_we; v.e_addr = e_addr;
    v.e_rv = e_rv; v.chk_d = chk_d; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdv, input logic wrv, input logic ireq, input logic [5:0] ra,
                       input logic [5:0] wa, input logic [63:0] wd, input logic [7:0] be);
    bus.rd_valid = rdv; bus.wr_valid = wrv; bus.init_req = ireq;
    bus.rd_addr  = ra;  bus.wr_addr  = wa;  bus.wr_data  = wd; bus.wr_be = be;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the controller in INIT and counter at zero.
  task automatic run_init(input string tag);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk({tag, "_addr"}, 64'(bus.sram_addr), 64'(i));
      chk({tag, "_ctl"}, {59'd0, bus.init_busy, bus.sram_cs, bus.sram_we, bus.rd_ready, bus.wr_ready},
          64'b11100);
      chk({tag, "_rvalid"}, 64'(bus.rd_rvalid), 64'd0);
      chk({tag, "_wdata_be"}, {bus.sram_wdata[55:0], bus.sram_wbyteenable}, {56'd0, 8'hFF});
      next_cycle();
    end
  endtask

  localparam logic [63:0] D_AA = 64'hAAAA_5555_AAAA_5555;
  localparam logic [63:0] D_11 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] D_DE = 64'hDEAD_BEEF_CAFE_F00D;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    //                  rdv  wrv ireq ra     wa     wd     be     rr wr cs we addr  rv chk rdata
    vt[0]  = mk(1, 0, 0, 6'd5, 6'd0, 64'd0, 8'h00, 1, 0, 1, 0, 6'd5, 0, 0, 64'd0);
    vt[1]  = mk(0, 0, 0, 6'd0, 6'd0, 64'd0, 8'h00, 0, 0, 0, 0, 6'd0, 1, 1, 64'd0);
    vt[2]  = mk(0, 1, 0, 6'd0, 6'd3, D_11,  8'h0F, 0, 1, 1, 1, 6'd3, 0, 0, 64'd0);
    vt[3]  = mk(1, 0, 0, 6'd3, 6'd0, 64'd0, 8'h00, 1, 0, 1, 0, 6'd3, 0, 0, 64'd0);
    vt[4]  = mk(0, 0, 0, 6'd0, 6'd0, 64'd0, 8'h00, 0, 0, 0, 0, 6'd0, 1, 1, 64'h0000_0000_5566_7788);
    vt[5]  = mk(1, 1, 0, 6'd7, 6'd8, D_AA,  8'hFF, 0, 1, 1, 1, 6'd8, 0, 0, 64'd0);
    vt[6]  = mk(1, 1, 0, 6'd7, 6'd8, D_AA,  8'hFF, 1, 0, 1, 0, 6'd7, 0, 0, 64'd0);
    vt[7]  = mk(1, 1, 0, 6'd7, 6'd8, D_AA,  8'hFF, 0, 1, 1, 1, 6'd8, 1, 1, 64'd0);
    vt[8]  = mk(1, 1, 0, 6'd7, 6'd8, D_AA,  8'hFF, 1, 0, 1, 0, 6'd7, 0, 0, 64'd0);
    vt[9]  = mk(1, 1, 0, 6'd7, 6'd8, D_AA,  8'hFF, 0, 1, 1, 1, 6'd8, 1, 1, 64'd0);
    vt[10] = mk(0, 1, 0, 6'd0, 6'd3, '1,    8'h00, 0, 1, 1, 1, 6'd3, 0, 0, 64'd0);
    vt[11] = mk(1, 0, 0, 6'd3, 6'd0, 64'd0, 8'h00, 1, 0, 1, 0, 6'd3, 0, 0, 64'd0);
    vt[12] = mk(0, 0, 0, 6'd0, 6'd0, 64'd0, 8'h00, 0, 0, 0, 0, 6'd0, 1, 1, 64'h0000_0000_5566_7788);
    vt[13] = mk(0, 1, 0, 6'd0, 6'd9, D_DE,  8'hFF, 0, 1, 1, 1, 6'd9, 0, 0, 64'd0);
    vt[14] = mk(1, 0, 0, 6'd9, 6'd0, 64'd0, 8'h00, 1, 0, 1, 0, 6'd9, 0, 0, 64'd0);
    // init_req the cycle after a read grant: no grant, response still arrives
    vt[15] = mk(1, 1, 1, 6'd9, 6'd10, 64'h1234, 8'hFF, 0, 0, 0, 0, 6'd0, 1, 1, D_DE);

    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom} | 64'h1;
    bus.sram_rdata = '0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Reset state
    @(negedge clk);
    chk("rst_busy", 64'(bus.init_busy), 64'd1);
    chk("rst_rvalid", 64'(bus.rd_rvalid), 64'd0);
    chk("rst_addr", 64'(bus.sram_addr), 64'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    run_init("init0");
    for (int a = 0; a < 64; a++) chk("init0_mem", mem[a], 64'd0);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].rdv, vt[i].wrv, vt[i].ireq, vt[i].ra, vt[i].wa, vt[i].wd, vt[i].be);
      @(negedge clk);
      chk($sformatf("v%0d_rd_ready", i), 64'(bus.rd_ready), 64'(vt[i].e_rr));
      chk($sformatf("v%0d_wr_ready", i), 64'(bus.wr_ready), 64'(vt[i].e_wr));
      chk($sformatf("v%0d_cs_we", i), {62'd0, bus.sram_cs, bus.sram_we}, {62'd0, vt[i].e_cs, vt[i].e_we});
      chk($sformatf("v%0d_addr", i), 64'(bus.sram_addr), 64'(vt[i].e_addr));
      chk($sformatf("v%0d_wdata", i), bus.sram_wdata, (vt[i].e_we ? vt[i].wd : 64'd0));
      chk($sformatf("v%0d_be", i), 64'(bus.sram_wbyteenable), (vt[i].e_we ? 64'(vt[i].be) : 64'd0));
      chk($sformatf("v%0d_rvalid", i), 64'(bus.rd_rvalid), 64'(vt[i].e_rv));
      if (vt[i].chk_d) chk($sformatf("v%0d_rdata", i), bus.rd_rdata, vt[i].e_rd);
      chk($sformatf("v%0d_busy", i), 64'(bus.init_busy), 64'd0);
      next_cycle();
    end

    // On-demand init with both requesters still waiting; prio was 1 (last grant read)
    drive(1, 1, 0, 6'd9, 6'd10, 64'h1234, 8'hFF);
    run_init("init1");
    @(negedge clk);
    chk("resume_w_grant", {62'd0, bus.rd_ready, bus.wr_ready}, 64'b01);
    chk("resume_w_addr", 64'(bus.sram_addr), 64'd10);
    next_cycle();
    @(negedge clk);
    chk("resume_r_grant", {62'd0, bus.rd_ready, bus.wr_ready}, 64'b10);
    next_cycle();
    @(negedge clk);
    chk("resume_w2_grant", {62'd0, bus.rd_ready, bus.wr_ready}, 64'b01);
    chk("resume_rvalid", 64'(bus.rd_rvalid), 64'd1);
    chk("resume_rdata_zeroed", bus.rd_rdata, 64'd0);
    next_cycle();

    // Reset in the middle of INIT restarts from address 0
    drive(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("ireq_no_grant", {61'd0, bus.sram_cs, bus.rd_ready, bus.wr_ready}, 64'd0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) next_cycle();
    @(negedge clk);
    chk("mid_init_addr", 64'(bus.sram_addr), 64'd20);
    rst = 1'b1;
    #1;
    chk("rst_mid_addr", 64'(bus.sram_addr), 64'd0);
    chk("rst_mid_rvalid", 64'(bus.rd_rvalid), 64'd0);
    next_cycle();
    rst = 1'b0;
    run_init("init2");

    // Contention from reset-idle: R,W,R,W,R,W
    drive(1, 1, 0, 6'd5, 6'd6, D_AA, 8'hFF);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_grant", k), {62'd0, bus.rd_ready, bus.wr_ready},
          ((k % 2) == 0) ? 64'b10 : 64'b01);
      chk($sformatf("rr%0d_rvalid", k), 64'(bus.rd_rvalid), 64'(k % 2));
      if ((k % 2) == 1) chk($sformatf("rr%0d_rdata", k), bus.rd_rdata, 64'd0);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rr_tail_rvalid", 64'(bus.rd_rvalid), 64'd0);
    chk("rr_tail_cs", 64'(bus.sram_cs), 64'd0);
    chk("rr_mem6", mem[6], D_AA);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hpdcache_sram_1rw_ctrl.md
Name: hpdcache_sram_1rw_ctrl

Overview:
- Shares one single-port byte-enable SRAM macro between a read requester and a write requester, using round-robin arbitration.
- Sequences a full-array zero initialisation after reset and on demand.
- Sits between the cache data/directory pipelines and one SRAM bank; owns every cs/we/addr decision for that bank.

Parameters:
- ADDR_SIZE, 6, SRAM address width.
- DATA_SIZE, 64, SRAM word width; must be a multiple of 8.
- DEPTH, 2**ADDR_SIZE, number of words to initialise.
- INIT_ON_RESET, 1, 1 = enter INIT state on reset release; 0 = enter RUN directly.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- init_req  in  1  pulse: request full-array zeroing
- init_busy  out  1  high while the INIT sequence runs
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request granted this cycle
- rd_addr  in  ADDR_SIZE  read address
- rd_rvalid  out  1  read data valid
- rd_rdata  out  DATA_SIZE  read data
- wr_valid  in  1  write request valid
- wr_ready  out  1  write request granted this cycle
- wr_addr  in  ADDR_SIZE  write address
- wr_data  in  DATA_SIZE  write data
- wr_be  in  DATA_SIZE/8  write byte enables
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_SIZE  SRAM address
- sram_wdata  out  DATA_SIZE  SRAM write data
- sram_wbyteenable  out  DATA_SIZE/8  SRAM byte enables
- sram_rdata  in  DATA_SIZE  SRAM read data, registered inside the macro, valid the cycle after a cs=1 access

Behaviour:
- States: INIT, RUN. Registered: state, init_cnt[ADDR_SIZE-1:0], rr_prio (0 = read preferred), rd_rvalid.
- Reset (asynchronous, while rst=1):
  - state = INIT if INIT_ON_RESET else RUN.
  - init_cnt = 0, rr_prio = 0, rd_rvalid = 0.
- INIT state:
  - Drives sram_cs=1, sram_we=1, sram_addr=init_cnt, sram_wdata=0, sram_wbyteenable all ones.
  - init_cnt increments each cycle. When init_cnt==DEPTH-1: that write completes, init_cnt returns to 0, next state is RUN.
  - Total duration is exactly DEPTH cycles.
  - init_busy=1; rd_ready=wr_ready=0; init_req is ignored.
- RUN state, in priority order:
  - init_req=1: state goes to INIT next cycle; no grant this cycle; sram_cs=0.
  - Only rd_valid: rd_ready=1.
  - Only wr_valid: wr_ready=1.
  - Both valid: grant read if rr_prio=0, otherwise grant write.
  - rr_prio updates on every grant: it becomes 1 after a read grant and 0 after a write grant, so contenders strictly alternate.
- Ready generation: rd_ready and wr_ready are combinational from the valids and state. At most one is high per cycle. Requesters must hold valid and payload stable until ready.
- SRAM drive, combinational from the granted request:
  - Read grant: cs=1, we=0, addr=rd_addr.
  - Write grant: cs=1, we=1, addr=wr_addr, wdata=wr_data, wbyteenable=wr_be.
  - No grant: cs=0, we=0; addr/wdata/be driven 0.
- Read response:
  - rd_rvalid is registered; it is 1 in the cycle after a read grant, for exactly one cycle.
  - rd_rdata = sram_rdata, passed straight through.
  - No backpressure on responses; back-to-back grants give back-to-back rd_rvalid.
- Ordering: accesses reach the SRAM in grant order. A read granted the cycle after a write to the same address returns the new data.
- A write with wr_be=0 is still granted and asserts cs/we; memory is unchanged.
- init_req arriving the cycle after a read grant: rd_rvalid still asserts for that read.
- Reset mid-INIT: the sequence restarts from address 0.
- The latency of INIT is independent of requester activity.

Test Plan:
- Reset with INIT_ON_RESET=1, DEPTH=64 → init_busy high for exactly 64 cycles, 64 writes to addresses 0..63 with data 0 and be=0xFF. Then a read of address 5 returns 0 with rd_rvalid one cycle after rd_ready.
- Write addr 3, data 0x1122334455667788, be=0x0F; then read addr 3 → rd_rdata=0x0000000055667788.
- rd_valid and wr_valid held high for 6 cycles from reset-idle → grants R,W,R,W,R,W; rd_rvalid is high in the cycle after each R grant.
- init_req pulsed while rd_valid/wr_valid are held → no grant in the init_req cycle, init_busy for 64 cycles, then arbitration resumes with the prior rr_prio.
- rst asserted when init_cnt=20 and released → INIT restarts at address 0 and runs the full 64 cycles; rd_rvalid is 0 throughout.
- Write addr 9 then immediate read addr 9 with data 0xDEADBEEF_CAFEF00D, be=0xFF → rd_rdata=0xDEADBEEFCAFEF00D.
